// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered, mutually aligned sync and blank.
// Optional frame pulse and frame counter are enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic             frame_start,
    output logic [15:0]      frame_count,
`endif
    output logic             blank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Decode thresholds carry one extra bit so a sync end equal to 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0] HS_START = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] H_VIS    = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] VS_START = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W:0] V_VIS    = (CNT_W+1)'(V_ACTIVE);

    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_blank;

    logic [CNT_W-1:0] w_hnext;
    logic [CNT_W-1:0] w_vnext;
    logic [CNT_W:0]   w_hExt;
    logic [CNT_W:0]   w_vExt;
    logic             w_hwrap;
    logic             w_vwrap;
    logic             w_hsyncNext;
    logic             w_vsyncNext;
    logic             w_blankNext;

    // Decode from next-state counters so every output register updates on the same edge as the counters.
    always_comb begin
        w_hwrap = (r_hcount == H_LAST);
        w_vwrap = (r_vcount == V_LAST);
        w_hnext = r_hcount + CNT_W'(1);
        w_vnext = r_vcount;
        if (w_hwrap) begin
            w_hnext = '0;
            w_vnext = w_vwrap ? '0 : r_vcount + CNT_W'(1);
        end
        w_hExt      = {1'b0, w_hnext};
        w_vExt      = {1'b0, w_vnext};
        w_hsyncNext = !((w_hExt >= HS_START) && (w_hExt < HS_END));
        w_vsyncNext = !((w_vExt >= VS_START) && (w_vExt < VS_END));
        w_blankNext = (w_hExt >= H_VIS) || (w_vExt >= V_VIS);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_blank  <= 1'b0;
        end else begin
            r_hcount <= w_hnext;
            r_vcount <= w_vnext;
            r_hsync  <= w_hsyncNext;
            r_vsync  <= w_vsyncNext;
            r_blank  <= w_blankNext;
        end
    end

    assign hcount = r_hcount;
    assign vcount = r_vcount;
    assign hsync  = r_hsync;
    assign vsync  = r_vsync;
    assign blank  = r_blank;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic        r_frameStart;
    logic [15:0] r_frameCount;

    // The pulse marks the cycle showing (0,0) after a real wrap; leaving reset never raises it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frameStart <= 1'b0;
            r_frameCount <= 16'd0;
        end else begin
            r_frameStart <= w_hwrap && w_vwrap;
            if (w_hwrap && w_vwrap) begin
                r_frameCount <= r_frameCount + 16'd1;
            end
        end
    end

    assign frame_start = r_frameStart;
    assign frame_count = r_frameCount;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter and a small-parameter instance checked every cycle
// against a cycle-count raster model through an expected-value queue.
module tb_vga_timing_gen;

    localparam int DH_A = 640, DH_F = 16, DH_S = 96, DH_B = 48;
    localparam int DV_A = 480, DV_F = 10, DV_S = 2,  DV_B = 33;
    localparam int SH_A = 8,   SH_F = 2,  SH_S = 3,  SH_B = 1;
    localparam int SV_A = 4,   SV_F = 1,  SV_S = 2,  SV_B = 1;
    localparam int RUN_CYCLES = 1700;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       bl;
    } pix_t;

    typedef struct packed {
        logic        fs;
        logic [15:0] fc;
    } frm_t;

    logic       clk;
    logic       clkRun;
    logic       reset_n;
    logic [9:0] hcDef, vcDef;
    logic       hsDef, vsDef, blDef;
    logic [3:0] hcSm, vcSm;
    logic       hsSm, vsSm, blSm;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic        fsDef, fsSm;
    logic [15:0] fcDef, fcSm;
`endif

    int   vectors;
    int   miscompares;
    int   t;
    int   firstLow;
    int   hsLowCnt;
    int   fsPulses;
    pix_t qDef[$];
    pix_t qSm[$];
    frm_t qFrmDef[$];
    frm_t qFrmSm[$];

    vga_timing_gen u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .hcount      (hcDef),
        .vcount      (vcDef),
        .hsync       (hsDef),
        .vsync       (vsDef),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start (fsDef),
        .frame_count (fcDef),
`endif
        .blank       (blDef)
    );

    vga_timing_gen #(
        .H_ACTIVE (SH_A), .H_FP (SH_F), .H_SYNC (SH_S), .H_BP (SH_B),
        .V_ACTIVE (SV_A), .V_FP (SV_F), .V_SYNC (SV_S), .V_BP (SV_B),
        .CNT_W    (4)
    ) u_small (
        .clk         (clk),
        .reset_n     (reset_n),
        .hcount      (hcSm),
        .vcount      (vcSm),
        .hsync       (hsSm),
        .vsync       (vsSm),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_start (fsSm),
        .frame_count (fcSm),
`endif
        .blank       (blSm)
    );

    always #5 if (clkRun) clk = ~clk;

    // Raster position follows purely from the number of edges since reset release.
    function automatic pix_t modelPix(int tc, int ha, int hf, int hsw, int hb,
                                      int va, int vf, int vsw, int vb);
        pix_t p;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int h  = tc % ht;
        int v  = (tc / ht) % vt;
        p.h  = 10'(h);
        p.v  = 10'(v);
        p.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
        p.vs = !((v >= va + vf) && (v < va + vf + vsw));
        p.bl = (h >= ha) || (v >= va);
        return p;
    endfunction

    function automatic frm_t modelFrm(int tc, int frameLen);
        frm_t f;
        f.fs = (tc != 0) && (tc % frameLen == 0);
        f.fc = 16'((tc / frameLen) % 65536);
        return f;
    endfunction

    task automatic pushExpected();
        qDef.push_back(modelPix(t, DH_A, DH_F, DH_S, DH_B, DV_A, DV_F, DV_S, DV_B));
        qSm.push_back(modelPix(t, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B));
        qFrmDef.push_back(modelFrm(t, (DH_A + DH_F + DH_S + DH_B) * (DV_A + DV_F + DV_S + DV_B)));
        qFrmSm.push_back(modelFrm(t, (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B)));
    endtask

    task automatic applyStimulus();
        t++;
        pushExpected();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        pix_t eD, eS, oD, oS;
        frm_t fD, fS;
        eD = qDef.pop_front();
        eS = qSm.pop_front();
        fD = qFrmDef.pop_front();
        fS = qFrmSm.pop_front();
        oD = {hcDef, vcDef, hsDef, vsDef, blDef};
        oS = {6'd0, hcSm, 6'd0, vcSm, hsSm, vsSm, blSm};
        vectors++;
        assert (oD === eD) else begin
            miscompares++;
            $error("[TB] FAIL %s default t=%0d observed h=%0d v=%0d hs=%b vs=%b bl=%b expected h=%0d v=%0d hs=%b vs=%b bl=%b",
                   tag, t, oD.h, oD.v, oD.hs, oD.vs, oD.bl, eD.h, eD.v, eD.hs, eD.vs, eD.bl);
        end
        vectors++;
        assert (oS === eS) else begin
            miscompares++;
            $error("[TB] FAIL %s small t=%0d observed h=%0d v=%0d hs=%b vs=%b bl=%b expected h=%0d v=%0d hs=%b vs=%b bl=%b",
                   tag, t, oS.h, oS.v, oS.hs, oS.vs, oS.bl, eS.h, eS.v, eS.hs, eS.vs, eS.bl);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        vectors++;
        assert ({fsDef, fcDef} === fD) else begin
            miscompares++;
            $error("[TB] FAIL %s_frame default t=%0d observed fs=%b fc=%0d expected fs=%b fc=%0d",
                   tag, t, fsDef, fcDef, fD.fs, fD.fc);
        end
        vectors++;
        assert ({fsSm, fcSm} === fS) else begin
            miscompares++;
            $error("[TB] FAIL %s_frame small t=%0d observed fs=%b fc=%0d expected fs=%b fc=%0d",
                   tag, t, fsSm, fcSm, fS.fs, fS.fc);
        end
`else
        if (fD.fs || fS.fs) begin
            t = t;
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        clkRun      = 1'b0;
        reset_n     = 1'b1;
        t           = 0;
        hsLowCnt    = 0;
        fsPulses    = 0;
        firstLow    = -1;

        // Reset with the clock stopped must take effect immediately.
        #3 reset_n = 1'b0;
        #1;
        t = 0;
        pushExpected();
        checkOutput("rst_clk_stopped");

        clkRun = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        t = 0;
        pushExpected();
        #1 checkOutput("pix00_release");

        for (int n = 0; n < RUN_CYCLES; n++) begin
            applyStimulus();
            checkOutput("run");
            if (t < 800 && hsDef === 1'b0) hsLowCnt++;
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (fsSm === 1'b1) fsPulses++;
`endif
        end

        vectors++;
        assert (hsLowCnt === 96) else begin
            miscompares++;
            $error("[TB] FAIL hsync_width observed=%0d expected=%0d", hsLowCnt, 96);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        vectors++;
        assert (fsPulses === RUN_CYCLES / 112) else begin
            miscompares++;
            $error("[TB] FAIL frame_pulses observed=%0d expected=%0d", fsPulses, RUN_CYCLES / 112);
        end
`endif

        // Advance the default instance to pixel (300,2) and abort the frame there.
        while (t < 1900) begin
            applyStimulus();
            checkOutput("run_to_midframe");
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        t = 0;
        pushExpected();
        checkOutput("rst_midframe_async");
        @(posedge clk);
        #1;
        pushExpected();
        checkOutput("rst_held");

        @(negedge clk);
        reset_n = 1'b1;
        t = 0;
        pushExpected();
        #1 checkOutput("pix00_after_midreset");

        for (int n = 0; n < 700; n++) begin
            applyStimulus();
            checkOutput("after_midreset");
            if (firstLow < 0 && hsDef === 1'b0) firstLow = t;
        end
        vectors++;
        assert (firstLow === 656) else begin
            miscompares++;
            $error("[TB] FAIL hsync_after_reset observed=%0d expected=%0d", firstLow, 656);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
